// File: rtl/mult_share_ctrl_if.sv
// mult_share_ctrl_if: requester-side and datapath-side signals of the shared multiplier controller
interface mult_share_ctrl_if #(parameter int WIDTH = 8);
    logic [1:0] Req, Gnt, Done;
    logic [WIDTH-1:0] OpA0, OpA1, OpB0, OpB1, Dp_S, Dp_B;
    logic [2*WIDTH-1:0] Result, Dp_Product;
    logic Busy, Dp_Clr_Ld, Dp_Add, Dp_Sub, Dp_Shift, Dp_M;
    modport master (
        output Req, OpA0, OpA1, OpB0, OpB1, Dp_M, Dp_Product,
        input  Gnt, Done, Result, Busy, Dp_S, Dp_B, Dp_Clr_Ld, Dp_Add, Dp_Sub, Dp_Shift
    );
    modport slave (
        input  Req, OpA0, OpA1, OpB0, OpB1, Dp_M, Dp_Product,
        output Gnt, Done, Result, Busy, Dp_S, Dp_B, Dp_Clr_Ld, Dp_Add, Dp_Sub, Dp_Shift
    );
endinterface

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin arbiter and shift-add sequencer sharing one signed multiplier datapath
module mult_share_ctrl #(parameter int WIDTH = 8) (
    input logic Clk,
    input logic Reset,
    mult_share_ctrl_if.slave bus
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);
    typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [KW-1:0] k;
    logic [1:0] elig;
    logic win, last, k_last;
    always_comb begin
        // a requester still seeing its own Done cannot be re-granted in that cycle
        elig = bus.Req & ~bus.Done;
        win = (elig == 2'b11) ? ~last : elig[1];
        k_last = (k == K_LAST);
        state_n = (state == IDLE)  ? ((|elig) ? LOAD : IDLE) :
                  (state == LOAD)  ? ADD :
                  (state == ADD)   ? SHIFT :
                  (state == SHIFT) ? (k_last ? DONE : ADD) : IDLE;
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            k <= '0;
            last <= 1'b1;
            bus.Gnt <= '0;
            bus.Done <= '0;
            bus.Result <= '0;
            bus.Dp_S <= '0;
            bus.Dp_B <= '0;
        end else begin
            bus.Done <= '0;
            if (state == IDLE && |elig) begin
                bus.Gnt <= win ? 2'b10 : 2'b01;
                bus.Dp_S <= win ? bus.OpA1 : bus.OpA0;
                bus.Dp_B <= win ? bus.OpB1 : bus.OpB0;
                last <= win;
            end
            if (state == LOAD) k <= '0;
            if (state == SHIFT && !k_last) k <= k + KW'(1);
            if (state == DONE) begin
                bus.Result <= bus.Dp_Product;
                bus.Gnt <= '0;
                bus.Done <= bus.Gnt;
            end
        end
    end
    // the MSB of a two's complement multiplier carries negative weight, hence the final subtract
    assign bus.Busy = (state != IDLE);
    assign bus.Dp_Clr_Ld = (state == LOAD);
    assign bus.Dp_Add = (state == ADD) & bus.Dp_M & ~k_last;
    assign bus.Dp_Sub = (state == ADD) & bus.Dp_M & k_last;
    assign bus.Dp_Shift = (state == SHIFT);
endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: scoreboard bench with a behavioural datapath and plain-arithmetic product model
module tb_mult_share_ctrl;
    localparam int W = 8;
    typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic [2*W-1:0] p;} job_t;
    logic Clk = 0, Reset = 0;
    int tests = 0, fails = 0;
    job_t q0[$], q1[$];
    int gnt_e[2], done_e[2];
    logic x;
    logic [W-1:0] acc, breg;

    mult_share_ctrl_if #(.WIDTH(W)) bus();
    mult_share_ctrl #(.WIDTH(W)) dut(.Clk(Clk), .Reset(Reset), .bus(bus));

    always #5 Clk = ~Clk;

    // datapath the controller drives: X:A accumulator, B multiplier register
    always @(posedge Clk) begin
        if (bus.Dp_Clr_Ld) begin x <= 1'b0; acc <= '0; breg <= bus.Dp_B; end
        else if (bus.Dp_Add) {x, acc} <= {x, acc} + {bus.Dp_S[W-1], bus.Dp_S};
        else if (bus.Dp_Sub) {x, acc} <= {x, acc} - {bus.Dp_S[W-1], bus.Dp_S};
        else if (bus.Dp_Shift) {x, acc, breg} <= {x, x, acc, breg[W-1:1]};
    end
    assign bus.Dp_M = breg[0];
    assign bus.Dp_Product = {acc, breg};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic job_t mk(input logic [W-1:0] a, input logic [W-1:0] b);
        job_t j;
        j.a = a;
        j.b = b;
        j.p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        return j;
    endfunction

    // monitor: arbitration order, latched operands, job length, strobe counts and products
    initial begin
        logic [1:0] prev_gnt, done_prev, elig, exp_g;
        logic last_m, id, stable_ok, excl_ok;
        int cnt, adds, subs;
        job_t j;
        prev_gnt = '0; done_prev = '0; last_m = 1'b1; id = 1'b0;
        cnt = 0; adds = 0; subs = 0; stable_ok = 1'b1; excl_ok = 1'b1;
        forever begin
            @(posedge Clk); #1;
            if (Reset) begin prev_gnt = '0; done_prev = '0; last_m = 1'b1; continue; end
            if (bus.Gnt != 0 && prev_gnt == 0) begin
                elig = bus.Req & ~done_prev;
                exp_g = (elig == 2'b11) ? (last_m ? 2'b01 : 2'b10) : elig;
                chk("arb", 32'(bus.Gnt), 32'(exp_g));
                id = bus.Gnt[1];
                last_m = id;
                cnt = 0; adds = 0; subs = 0; stable_ok = 1'b1; excl_ok = 1'b1;
                chk("pending_at_grant", 32'((id ? q1.size() : q0.size()) != 0), 1);
                if ((id ? q1.size() : q0.size()) != 0) begin
                    j = id ? q1[0] : q0[0];
                    chk("latch_s", 32'(bus.Dp_S), 32'(j.a));
                    chk("latch_b", 32'(bus.Dp_B), 32'(j.b));
                end
                chk("busy_job", 32'(bus.Busy), 1);
            end
            if (bus.Gnt != 0) begin
                cnt++;
                adds += 32'(bus.Dp_Add);
                subs += 32'(bus.Dp_Sub);
                if (bus.Dp_S != j.a || bus.Dp_B != j.b) stable_ok = 1'b0;
            end
            if ($countones({bus.Dp_Clr_Ld, bus.Dp_Add, bus.Dp_Sub, bus.Dp_Shift}) > 1) excl_ok = 1'b0;
            if (prev_gnt != 0 && bus.Gnt == 0) begin
                chk("done", 32'(bus.Done), 32'(prev_gnt));
                chk("pending_at_done", 32'((id ? q1.size() : q0.size()) != 0), 1);
                if ((id ? q1.size() : q0.size()) != 0) begin
                    j = id ? q1.pop_front() : q0.pop_front();
                    chk("result", 32'(bus.Result), 32'(j.p));
                    chk("gnt_len", cnt, 2 * W + 2);
                    chk("adds", adds, 32'($countones(j.b[W-2:0])));
                    chk("subs", subs, 32'(j.b[W-1]));
                    chk("stable", 32'(stable_ok), 1);
                    chk("excl", 32'(excl_ok), 1);
                    chk("busy_done", 32'(bus.Busy), 0);
                end
            end else if (bus.Done != 0) chk("spurious_done", 32'(bus.Done), 0);
            prev_gnt = bus.Gnt;
            done_prev = bus.Done;
        end
    end

    task automatic do_reset();
        @(posedge Clk); #3 Reset = 1;
        bus.Req = '0;
        q0.delete();
        q1.delete();
        repeat (2) @(posedge Clk);
        #3 Reset = 0;
    endtask

    task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
        if (r == 0) begin bus.OpA0 = a; bus.OpB0 = b; end
        else begin bus.OpA1 = a; bus.OpB1 = b; end
    endtask

    // requester side: raise Req, scramble operands once granted, drop Req one cycle after Done
    task automatic run(input logic [1:0] m, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] early);
        logic [1:0] pend, drop, seen;
        int n;
        @(posedge Clk); #2;
        set_ops(0, a0, b0);
        set_ops(1, a1, b1);
        if (m[0]) q0.push_back(mk(a0, b0));
        if (m[1]) q1.push_back(mk(a1, b1));
        bus.Req = bus.Req | m;
        pend = m; drop = '0; seen = '0; n = 0;
        gnt_e = '{-1, -1}; done_e = '{-1, -1};
        while (pend != 0 && n < 200) begin
            @(posedge Clk); #2;
            n++;
            bus.Req = bus.Req & ~drop;
            drop = '0;
            for (int r = 0; r < 2; r++) begin
                if (bus.Gnt[r] && !seen[r]) begin
                    seen[r] = 1'b1;
                    gnt_e[r] = n;
                    set_ops(r, W'($urandom), W'($urandom));
                end
                if (early[r] && seen[r] && n == gnt_e[r] + 4) bus.Req[r] = 1'b0;
                if (bus.Done[r] && pend[r]) begin
                    done_e[r] = n;
                    drop[r] = 1'b1;
                    pend[r] = 1'b0;
                end
            end
        end
        chk("timeout", 32'(pend), 0);
        @(posedge Clk); #2;
        bus.Req = '0;
        if (pend != 0) do_reset();
    endtask

    initial begin
        logic [1:0] m;
        bus.Req = '0;
        set_ops(0, '0, '0);
        set_ops(1, '0, '0);
        #1 Reset = 1;
        #2;
        chk("rst_gnt", 32'(bus.Gnt), 0);
        chk("rst_done", 32'(bus.Done), 0);
        chk("rst_busy", 32'(bus.Busy), 0);
        chk("rst_result", 32'(bus.Result), 0);
        chk("rst_dp_s", 32'(bus.Dp_S), 0);
        chk("rst_dp_b", 32'(bus.Dp_B), 0);
        chk("rst_strobes", 32'({bus.Dp_Clr_Ld, bus.Dp_Add, bus.Dp_Sub, bus.Dp_Shift}), 0);
        repeat (2) @(posedge Clk);
        #3 Reset = 0;

        run(2'b01, 8'd5, 8'd6, 8'd0, 8'd0, 2'b00);
        chk("lat_gnt", gnt_e[0], 1);
        chk("lat_done", done_e[0], 19);
        chk("res_5x6", 32'(bus.Result), 32'h001E);
        run(2'b10, 8'd0, 8'd0, 8'd7, 8'hFD, 2'b00);
        chk("res_7xm3", 32'(bus.Result), 32'hFFEB);
        run(2'b01, 8'h80, 8'h80, 8'd0, 8'd0, 2'b00);
        chk("res_m128sq", 32'(bus.Result), 32'h4000);
        run(2'b01, 8'h55, 8'h00, 8'd0, 8'd0, 2'b00);
        chk("res_zero", 32'(bus.Result), 32'h0000);

        do_reset();
        run(2'b11, 8'd11, 8'hF6, 8'h93, 8'd37, 2'b00);
        chk("tie_first", gnt_e[0], 1);
        chk("b2b_gap", gnt_e[1], done_e[0] + 1);

        @(posedge Clk); #2;
        set_ops(0, 8'd100, 8'd3);
        q0.push_back(mk(8'd100, 8'd3));
        bus.Req = 2'b01;
        repeat (11) @(posedge Clk);
        #2 chk("pre_abort_gnt", 32'(bus.Gnt), 1);
        #1 Reset = 1;
        #1;
        chk("abort_gnt", 32'(bus.Gnt), 0);
        chk("abort_busy", 32'(bus.Busy), 0);
        chk("abort_done", 32'(bus.Done), 0);
        chk("abort_strobes", 32'({bus.Dp_Clr_Ld, bus.Dp_Add, bus.Dp_Sub, bus.Dp_Shift}), 0);
        bus.Req = '0;
        q0.delete();
        repeat (2) @(posedge Clk);
        #3 Reset = 0;
        run(2'b01, 8'hF3, 8'h7B, 8'd0, 8'd0, 2'b00);

        run(2'b01, 8'h9C, 8'h2D, 8'd0, 8'd0, 2'b01);

        for (int i = 0; i < 30; i++) begin
            m = 2'($urandom_range(1, 3));
            run(m, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 2'($urandom) & m);
        end

        repeat (3) @(posedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequencer and round-robin arbiter that shares one signed shift-add multiplier datapath (sign bit X, accumulator A, multiplier register B) between two requesters. It latches the granted requester's operands and drives the datapath's clear/load, add, subtract and shift strobes for a full WIDTH-bit signed multiply. It captures the 2·WIDTH-bit product and returns it with a one-cycle Done pulse. It sits between the requester-side logic and the existing multiplier register/adder datapath.

## Interface
- WIDTH, 8, operand width in bits; product is 2·WIDTH bits.
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  2  request level per requester; bit i = requester i.
- OpA0, OpA1  in  WIDTH  multiplicand per requester, signed two's complement.
- OpB0, OpB1  in  WIDTH  multiplier per requester, signed two's complement.
- Gnt  out  2  one-hot grant; high for the whole job.
- Done  out  2  one-cycle completion pulse to the finished requester.
- Result  out  2·WIDTH  last product, held until the next capture.
- Busy  out  1  high when the controller is not in IDLE.
- Dp_S  out  WIDTH  latched multiplicand presented to the datapath adder.
- Dp_B  out  WIDTH  latched multiplier, loaded into B on Dp_Clr_Ld.
- Dp_Clr_Ld  out  1  datapath clears X and A, and loads B.
- Dp_Add  out  1  A <= A + Dp_S, with sign-extended X update.
- Dp_Sub  out  1  A <= A − Dp_S, with sign-extended X update.
- Dp_Shift  out  1  arithmetic right shift of {X,A,B}.
- Dp_M  in  1  current LSB of B.
- Dp_Product  in  2·WIDTH  {A,B} from the datapath.

## Operation
- States: IDLE, LOAD, ADD, SHIFT, DONE. Bit counter k runs 0..WIDTH−1.
- **IDLE**
  - Eligible requesters are those with Req high, excluding any requester whose Done is high this cycle.
  - Single eligible requester: grant it. Two eligible: grant the requester not served last. After reset, a tie goes to requester 0.
  - On grant at the clock edge: Gnt set, OpA/OpB of the winner latched into Dp_S/Dp_B, last-served pointer updated, state goes to LOAD.
- **LOAD**: Dp_Clr_Ld=1; k<=0; next state ADD.
- **ADD**: Dp_Add = Dp_M & (k≠WIDTH−1); Dp_Sub = Dp_M & (k=WIDTH−1); next state SHIFT.
- **SHIFT**: Dp_Shift=1. If k=WIDTH−1, go to DONE; otherwise k<=k+1 and go to ADD.
- **DONE**: no datapath strobes. At the ending edge: Result<=Dp_Product, Gnt<=0, Done[granted]<=1 (registered), state goes to IDLE.
- Strobes are mutually exclusive and are all zero outside their states.
- Dp_S and Dp_B are stable from LOAD through DONE. Requester operands may change any time after Gnt rises.
- Req deasserted mid-job: the job still completes, Done still pulses, Result is still updated. There is no abort.
- Requesters must drop Req in the cycle Done is seen. Done-masking prevents an immediate re-grant in that cycle. Req still high one cycle later counts as a new request.
- Arithmetic is signed WIDTH×WIDTH → 2·WIDTH. Wrap-around cannot occur because X holds the extra sign bit.

## Timing
- Reset values: state IDLE, Gnt=0, Done=0, Result=0, Busy=0, Dp_S=0, Dp_B=0, all Dp_* strobes 0, pointer favours requester 0.
- Reset mid-job aborts immediately:
  - no Done pulse is issued;
  - datapath contents are don't-care;
  - the next grant restarts from LOAD.
- Latency, Req rising in an IDLE cycle t:
  - Gnt high in t+1 (LOAD);
  - ADD/SHIFT occupy t+2..t+2W+1;
  - DONE at t+2W+2;
  - Done pulse and valid Result at t+2W+3. For WIDTH=8 this is 19 cycles.
- Gnt is high for exactly 2·WIDTH+2 cycles.
- Back-to-back: the Done cycle is an IDLE cycle in which the other requester may win. Its Gnt rises in the next cycle, so jobs are spaced 2W+3 cycles apart.
- Simultaneous Req rising in the same IDLE cycle: tie rule applies, and the loser is served next.
- Busy = (state ≠ IDLE). Busy is low during the Done cycle.

## Test plan
- Req0 alone, OpA0=5, OpB0=6 -> Gnt=01 at cycle 1; Done=01 at cycle 19; Result=0x001E.
- Req1 alone, OpA1=7, OpB1=−3 (0xFD) -> Dp_Sub exactly once, in the last ADD; Result=0xFFEB.
- OpA0=−128, OpB0=−128 -> Result=0x4000. Also OpA0=0x55, OpB0=0 -> no Dp_Add/Dp_Sub pulses and Result=0x0000.
- Both Req high from reset, held, each dropped on its own Done -> grants in order 0,1. Second Gnt rises one cycle after the first Done. Requester 0 is never re-granted in its own Done cycle.
- Reset asserted at cycle 10 of a job -> Gnt, Done, Busy and all strobes 0 asynchronously. Re-request completes with a correct product.
- OpA0/OpB0 changed right after Gnt, and Req0 dropped at cycle 5 -> Dp_S/Dp_B unchanged, Done still pulses, Result matches the latched operands.
